battle_board: RTL

BATTLE_BOARD -- requirements
Module: battle_board

---
 rtl/battle_board.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/battle_board.sv
// battle_board: ship-map loader plus a fire/response game controller.
// Build option: define BATTLE_BOARD_REPEAT_PENALTY_EN to charge one turn for
// firing again at an in-range cell that has already been resolved.
//
//   state | meaning
//   LOAD  | ship map writable, waiting for start with at least one ship
//   PLAY  | fires accepted, one response per fire on the following cycle
//   WON   | every ship sunk; terminal until reset
//   LOST  | turns exhausted with ships remaining; terminal until reset
module battle_board #(
   parameter int ROWS      = 10,
   parameter int COLS      = 10,
   parameter int NUM_SHIPS = 5,
   parameter int MAX_TURNS = 15
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load_we_i,
   input  logic [3:0]               load_row_i,
   input  logic [3:0]               load_col_i,
   input  logic [2:0]               load_id_i,
   input  logic                     start_i,
   input  logic                     fire_valid_i,
   input  logic [3:0]               fire_row_i,
   input  logic [3:0]               fire_col_i,
   output logic                     fire_ready_o,
   output logic                     rsp_valid_o,
   output logic [1:0]               rsp_code_o,
   output logic [2:0]               rsp_ship_o,
   output logic [2*ROWS*COLS-1:0]   cell_status_flat_o,
   output logic [4:0]               turns_left_o,
   output logic [2:0]               ships_left_o,
   output logic [1:0]               state_o
);
   localparam int CELLS = ROWS * COLS;
   localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;

   localparam logic [1:0] S_LOAD = 2'd0;
   localparam logic [1:0] S_PLAY = 2'd1;
   localparam logic [1:0] S_WON  = 2'd2;
   localparam logic [1:0] S_LOST = 2'd3;

   localparam logic [1:0] ST_UNK  = 2'd0;
   localparam logic [1:0] ST_MISS = 2'd1;
   localparam logic [1:0] ST_HIT  = 2'd2;
   localparam logic [1:0] ST_SUNK = 2'd3;

   logic [2:0] map_q    [CELLS];
   logic [1:0] status_q [CELLS];
   logic [8:0] len_q    [8];
   logic [8:0] hits_q   [8];
   logic [1:0] state_q;
   logic [4:0] turns_q;
   logic [2:0] ships_q;
   logic       rsp_valid_q;
   logic [1:0] rsp_code_q;
   logic [2:0] rsp_ship_q;

   logic [IW-1:0] ld_idx, fr_idx;
   logic          ld_in, load_ok;
   logic          fire_acc, fr_in, fr_fresh, fr_miss, fr_hit, fr_sunk;
   logic [2:0]    fr_id;
   logic [2:0]    ship_cnt;
   logic [1:0]    rsp_code_d;
   logic [2:0]    rsp_ship_d;
`ifdef BATTLE_BOARD_REPEAT_PENALTY_EN
   logic          fr_repeat;
`endif

   assign ld_idx  = IW'(int'(load_row_i) * COLS + int'(load_col_i));
   assign ld_in   = ({1'b0, load_row_i} < 5'(ROWS)) && ({1'b0, load_col_i} < 5'(COLS));
   // First nonzero write to a cell owns it; zero and unused IDs never land.
   assign load_ok = (state_q == S_LOAD) && load_we_i && ld_in && (load_id_i != 3'd0)
                    && (load_id_i <= 3'(NUM_SHIPS)) && (map_q[ld_idx] == 3'd0);

   assign fr_idx   = IW'(int'(fire_row_i) * COLS + int'(fire_col_i));
   assign fr_in    = ({1'b0, fire_row_i} < 5'(ROWS)) && ({1'b0, fire_col_i} < 5'(COLS));
   assign fire_acc = fire_valid_i && (state_q == S_PLAY);
   assign fr_id    = map_q[fr_idx];
   assign fr_fresh = fr_in && (status_q[fr_idx] == ST_UNK);
   assign fr_miss  = fr_fresh && (fr_id == 3'd0);
   assign fr_hit   = fr_fresh && (fr_id != 3'd0);
   assign fr_sunk  = fr_hit && ((hits_q[fr_id] + 9'd1) == len_q[fr_id]);
`ifdef BATTLE_BOARD_REPEAT_PENALTY_EN
   assign fr_repeat = fr_in && !fr_fresh;
`endif

   // Ships present at start, including a write landing in the same cycle.
   always_comb begin
      ship_cnt = 3'd0;
      for (int k = 1; k <= NUM_SHIPS; k++) begin
         if ((len_q[k] != 9'd0) || (load_ok && (load_id_i == 3'(k))))
            ship_cnt = ship_cnt + 3'd1;
      end
   end

   // Response encoding for the fire being accepted this cycle.
   always_comb begin
      rsp_code_d = 2'b00;
      rsp_ship_d = 3'd0;
      if (fire_acc) begin
         if (fr_miss) begin
            rsp_code_d = 2'b01;
         end else if (fr_hit) begin
            rsp_code_d = fr_sunk ? 2'b11 : 2'b10;
            rsp_ship_d = fr_id;
         end
      end
   end

   // Board state, counters, FSM and registered response.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_LOAD;
         turns_q     <= 5'(MAX_TURNS);
         ships_q     <= 3'd0;
         rsp_valid_q <= 1'b0;
         rsp_code_q  <= 2'b00;
         rsp_ship_q  <= 3'd0;
         for (int i = 0; i < CELLS; i++) begin
            map_q[i]    <= 3'd0;
            status_q[i] <= ST_UNK;
         end
         for (int k = 0; k < 8; k++) begin
            len_q[k]  <= 9'd0;
            hits_q[k] <= 9'd0;
         end
      end else begin
         rsp_valid_q <= fire_acc;
         rsp_code_q  <= rsp_code_d;
         rsp_ship_q  <= rsp_ship_d;
         case (state_q)
            S_LOAD: begin
               if (load_ok) begin
                  map_q[ld_idx]    <= load_id_i;
                  len_q[load_id_i] <= len_q[load_id_i] + 9'd1;
               end
               if (start_i && (ship_cnt != 3'd0)) begin
                  ships_q <= ship_cnt;
                  state_q <= S_PLAY;
               end
            end
            S_PLAY: begin
               if (fire_acc) begin
                  if (fr_miss) begin
                     status_q[fr_idx] <= ST_MISS;
                     turns_q          <= turns_q - 5'd1;
                     if (turns_q == 5'd1)
                        state_q <= S_LOST;
                  end else if (fr_hit) begin
                     status_q[fr_idx] <= ST_HIT;
                     hits_q[fr_id]    <= hits_q[fr_id] + 9'd1;
                     if (fr_sunk) begin
                        for (int i = 0; i < CELLS; i++) begin
                           if (map_q[i] == fr_id)
                              status_q[i] <= ST_SUNK;
                        end
                        ships_q <= ships_q - 3'd1;
                        if (ships_q == 3'd1)
                           state_q <= S_WON;
                     end
`ifdef BATTLE_BOARD_REPEAT_PENALTY_EN
                  end else if (fr_repeat) begin
                     turns_q <= turns_q - 5'd1;
                     if (turns_q == 5'd1)
                        state_q <= S_LOST;
`endif
                  end
               end
            end
            default: ;
         endcase
      end
   end

   for (genvar i = 0; i < CELLS; i++) begin : g_flat
      assign cell_status_flat_o[2*i +: 2] = status_q[i];
   end

   assign fire_ready_o = (state_q == S_PLAY);
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_code_o   = rsp_code_q;
   assign rsp_ship_o   = rsp_ship_q;
   assign turns_left_o = turns_q;
   assign ships_left_o = ships_q;
   assign state_o      = state_q;
endmodule
